pc_select_reg: RTL and testbench
================================

# pc_select_reg

Parametrised program-counter selection register for the pipeline fetch stage. It picks the next PC from N prioritised redirect targets or a sequential increment, and registers the result as the fetch address. It also implements the run / single-step / halt control that the debug unit drives. It generalises the 2:1 PC mux: N sources, a fixed priority, and stall handling in a state-holding register.

## Interface
Parameters:
- PC_SIZE, 32, width of PC and of every target.
- N_SRC, 4, number of redirect sources (branch, jump, jump-register, debug load…), ≥1.
- SRC_W, $clog2(N_SRC+1), width of the source-id output.
- RESET_PC, 0, PC value after reset.
- PC_STEP, 4, sequential increment.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  N_SRC  redirect requests; bit k requests target k.
- i_targets  in  N_SRC*PC_SIZE  flattened targets; target k = bits [k*PC_SIZE +: PC_SIZE].
- i_stall  in  1  hazard stall; PC holds.
- i_start  in  1  leave IDLE.
- i_mode  in  1  sampled with i_start: 0 = continuous run, 1 = single-step.
- i_step  in  1  one-cycle advance pulse in step mode.
- i_halt  in  1  halt instruction detected.
- o_pc  out  PC_SIZE  registered fetch address.
- o_src  out  SRC_W  registered id of the source that produced o_pc: 0 = sequential, k+1 = i_req[k].
- o_valid  out  1  registered pulse: o_pc was updated on the last edge.
- o_halted  out  1  registered, high in HALTED.

## Operation
- Next-PC candidate (combinational):
  - The highest set index k of i_req wins and gives i_targets[k].
  - If no request is set, the candidate is o_pc + PC_STEP, truncated to PC_SIZE. It wraps modulo 2^PC_SIZE with no flag.
- Advance condition depends on state:
  - IDLE: never advances.
  - RUN: advances when !i_stall && !i_halt.
  - STEP: advances when i_step && !i_stall && !i_halt.
  - HALTED: never advances.
- On advance, o_pc takes the candidate, o_src takes the winning id, and o_valid goes 1 for one cycle.
- Without advance, o_pc and o_src hold and o_valid is 0.
- Requests that arrive while not advancing are dropped. The requester must hold i_req until it sees o_valid.
- State machine:
  - IDLE → RUN on i_start && !i_mode.
  - IDLE → STEP on i_start && i_mode.
  - RUN → HALTED on i_halt.
  - STEP → HALTED on i_halt.
  - HALTED is sticky; only i_reset leaves it.
  - i_start is ignored outside IDLE. i_step is ignored outside STEP.
- Simultaneous events:
  - i_halt with i_req or i_step: halt wins, PC holds.
  - i_stall with i_req: stall wins, request dropped.
  - Multiple i_req bits: highest index wins.
  - i_start and i_halt together in IDLE: enter RUN/STEP; i_halt is not acted on until the next cycle.

## Timing
- Reset (async assert, sync release):
  - o_pc = RESET_PC, o_src = 0, o_valid = 0, o_halted = 0, state = IDLE.
  - Reset mid-run discards any pending advance immediately.
- Latency:
  - A request accepted on edge n appears on o_pc after edge n, with o_valid high during cycle n+1.
  - First advance after i_start happens on the edge after the one that samples i_start.
- o_halted rises the cycle after i_halt is sampled in RUN or STEP.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Package pc_select_pkg holds:
  - the state enum (IDLE, RUN, STEP, HALTED);
  - the mode constants MODE_RUN = 0 and MODE_STEP = 1.
- Sub-module prio_enc: parametrised N_SRC-bit highest-index priority encoder with outputs found and idx. Instantiated once.
- The next-PC candidate uses an indexed part-select of i_targets. No per-source logic is duplicated.

## Test plan
All scenarios use PC_SIZE = 32, N_SRC = 4 and PC_STEP = 4.
- Reset and sequential run: reset, then i_start = 1 with i_mode = 0 and no requests.
  - o_pc goes 0, 4, 8, 12 on successive edges, o_src = 0, o_valid high each cycle.
- Priority: in RUN, i_req = 4'b0110 with target1 = 0x100 and target2 = 0x200.
  - o_pc = 0x200 and o_src = 3 after one edge.
- Stall: i_stall high for 3 cycles while i_req[0] is set.
  - o_pc holds and o_valid = 0 during the stall.
  - The request is accepted on the first unstalled edge when i_req is held.
- Step mode: i_start with i_mode = 1, then i_step pulses at cycles 5 and 9.
  - o_pc advances exactly twice (0→4→8), with o_valid only after each pulse.
  - A pulse coinciding with i_stall produces no advance.
- Halt: i_halt at PC = 0x20 together with i_req[3].
  - o_pc stays 0x20 and o_halted = 1 the next cycle.
  - It stays halted through i_start and i_step, and returns to IDLE/RESET_PC only on i_reset.
- Wrap and async reset: RESET_PC = 0xFFFFFFFC in RUN gives next o_pc = 0x0.
  - Asserting i_reset mid-cycle clears all outputs before the next edge.

Source files
------------

// File: rtl/pc_select_pkg.sv
// Shared types and constants for the PC selection register.
package pc_select_pkg;

  // Control states of the fetch PC sequencer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_e;

  // Value of i_mode sampled together with i_start.
  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/pc_select_reg_prio_enc.sv
// Highest-index-wins priority encoder for the redirect request vector.
module prio_enc
  import pc_select_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scan upward so the last (highest) set bit overwrites lower ones.
  always_comb begin
    o_found = 1'b0;
    o_idx   = {IDX_W{1'b0}};
    for (int k = 0; k < N_SRC; k++) begin
      if (i_req[k]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(k);
      end else begin
        o_found = o_found;
        o_idx   = o_idx;
      end
    end
  end

endmodule

// File: rtl/pc_select_reg.sv
// Fetch-stage PC selection register: prioritised redirects or sequential
// increment, gated by run / single-step / halt control from the debug unit.
module pc_select_reg
  import pc_select_pkg::*;
#(
  parameter int                  PC_SIZE  = 32,
  parameter int                  N_SRC    = 4,
  parameter int                  SRC_W    = $clog2(N_SRC + 1),
  parameter logic [PC_SIZE-1:0]  RESET_PC = {PC_SIZE{1'b0}},
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_SRC-1:0]           i_req,
  input  logic [N_SRC*PC_SIZE-1:0]   i_targets,
  input  logic                       i_stall,
  input  logic                       i_start,
  input  logic                       i_mode,
  input  logic                       i_step,
  input  logic                       i_halt,
  output logic [PC_SIZE-1:0]         o_pc,
  output logic [SRC_W-1:0]           o_src,
  output logic                       o_valid,
  output logic                       o_halted
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  pc_state_e          state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic               found_s;
  logic [IDX_W-1:0]   idx_s;
  logic               advance_s;
  logic [PC_SIZE-1:0] cand_pc_s;
  logic [SRC_W-1:0]   cand_src_s;

  prio_enc #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (i_req),
    .o_found (found_s),
    .o_idx   (idx_s)
  );

  // Next-PC candidate: winning redirect target, else sequential (wrapping) increment.
  always_comb begin
    cand_pc_s  = pc_q + PC_SIZE'(PC_STEP);
    cand_src_s = {SRC_W{1'b0}};
    if (found_s) begin
      cand_pc_s  = i_targets[int'(idx_s) * PC_SIZE +: PC_SIZE];
      cand_src_s = SRC_W'(idx_s) + SRC_W'(1);
    end else begin
      cand_pc_s  = pc_q + PC_SIZE'(PC_STEP);
      cand_src_s = {SRC_W{1'b0}};
    end
  end

  // Control FSM: next state and whether the PC advances this cycle.
  always_comb begin
    state_d   = state_q;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        advance_s = 1'b0;
        if (i_start) begin
          case (i_mode)
            MODE_RUN:  state_d = ST_RUN;
            MODE_STEP: state_d = ST_STEP;
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        advance_s = !i_stall && !i_halt;
        if (i_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        advance_s = i_step && !i_stall && !i_halt;
        if (i_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_HALTED: begin
        advance_s = 1'b0;
        state_d   = ST_HALTED;
      end
      default: begin
        advance_s = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Output register next values: load candidate on advance, otherwise hold.
  always_comb begin
    pc_d     = pc_q;
    src_d    = src_q;
    valid_d  = 1'b0;
    halted_d = (state_d == ST_HALTED);
    if (advance_s) begin
      pc_d    = cand_pc_s;
      src_d   = cand_src_s;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q;
      src_d   = src_q;
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any pending advance at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      src_q    <= {SRC_W{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign o_pc     = pc_q;
  assign o_src    = src_q;
  assign o_valid  = valid_q;
  assign o_halted = halted_q;

endmodule

// File: tb/tb_pc_select_reg.sv
// Self-checking bench for pc_select_reg: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_pc_select_reg;

  localparam int PCW = 32;
  localparam int NS  = 4;
  localparam int SW  = 3;

  logic            i_clk = 1'b0;
  logic            rst   = 1'b1;
  logic [NS-1:0]   req   = '0;
  logic [NS*PCW-1:0] tg  = '0;
  logic            stall = 1'b0;
  logic            start = 1'b0;
  logic            mode  = 1'b0;
  logic            step  = 1'b0;
  logic            halt  = 1'b0;

  logic [PCW-1:0]  pc, w_pc;
  logic [SW-1:0]   src, w_src;
  logic            valid, w_valid, halted, w_halted;

  always #5 i_clk = ~i_clk;

  pc_select_reg #(.PC_SIZE(PCW), .N_SRC(NS), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .i_clk(i_clk), .i_reset(rst), .i_req(req), .i_targets(tg), .i_stall(stall),
    .i_start(start), .i_mode(mode), .i_step(step), .i_halt(halt),
    .o_pc(pc), .o_src(src), .o_valid(valid), .o_halted(halted));

  pc_select_reg #(.PC_SIZE(PCW), .N_SRC(NS), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .i_clk(i_clk), .i_reset(rst), .i_req(req), .i_targets(tg), .i_stall(stall),
    .i_start(start), .i_mode(mode), .i_step(step), .i_halt(halt),
    .o_pc(w_pc), .o_src(w_src), .o_valid(w_valid), .o_halted(w_halted));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: started / step-mode / halted flags plus PC values.
  logic [31:0] m_pc, m_wpc;
  logic [2:0]  m_src;
  bit          m_valid, m_halted, m_started, m_stepmode;

  function automatic void model_reset();
    m_pc = 32'h0; m_wpc = 32'hFFFF_FFFC; m_src = 3'd0;
    m_valid = 1'b0; m_halted = 1'b0; m_started = 1'b0; m_stepmode = 1'b0;
  endfunction

  function automatic void model_edge();
    bit adv;
    int win;
    logic [31:0] t;
    adv = m_started && !m_halted && !stall && !halt && (!m_stepmode || step);
    win = -1;
    for (int k = NS - 1; k >= 0; k--)
      if (req[k] && win < 0) win = k;
    if (adv) begin
      if (win >= 0) begin
        t = tg[win*PCW +: PCW];
        m_pc = t; m_wpc = t; m_src = 3'(win + 1);
      end else begin
        m_pc = m_pc + 32'd4; m_wpc = m_wpc + 32'd4; m_src = 3'd0;
      end
    end
    m_valid = adv;
    if (!m_started) begin
      if (start) begin m_started = 1'b1; m_stepmode = mode; end
    end else if (halt) begin
      m_halted = 1'b1;
    end
  endfunction

  task automatic check_model(string tag);
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " wrap_pc"}, w_pc, m_wpc);
    chk({tag, " src"}, 32'(src), 32'(m_src));
    chk({tag, " valid"}, 32'(valid), 32'(m_valid));
    chk({tag, " halted"}, 32'(halted), 32'(m_halted));
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    req = '0; stall = 1'b0; start = 1'b0; mode = 1'b0; step = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    rst = 1'b0;
    check_model("reset");
  endtask

  typedef struct {
    logic        start, mode;
    logic [3:0]  req;
    logic        stall, step, halt;
    logic [31:0] epc, ewpc;
    logic [2:0]  esrc;
    logic        ev, eh;
  } vec_t;

  vec_t tbl[14];
  int   vcount;

  initial begin
    // start, mode, req, stall, step, halt, pc, wrap_pc, src, valid, halted
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h000, 32'hFFFF_FFFC, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h004, 32'h000, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h008, 32'h004, 3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00C, 32'h008, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h200, 32'h200, 3'd3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h200, 32'h200, 3'd3, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h200, 32'h200, 3'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h200, 32'h200, 3'd3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h040, 32'h040, 3'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h044, 32'h044, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h048, 32'h048, 3'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h04C, 32'h04C, 3'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h04C, 32'h04C, 3'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h04C, 32'h04C, 3'd0, 1'b0, 1'b1};

    // Directed vector table.
    tg = {32'h300, 32'h200, 32'h100, 32'h040};
    do_reset();
    chk("reset pc", pc, 32'h0);
    chk("reset wrap_pc", w_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start; mode = tbl[i].mode; req = tbl[i].req;
      stall = tbl[i].stall; step = tbl[i].step; halt = tbl[i].halt;
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d pc", i), pc, tbl[i].epc);
      chk($sformatf("vec%0d wrap_pc", i), w_pc, tbl[i].ewpc);
      chk($sformatf("vec%0d src", i), 32'(src), 32'(tbl[i].esrc));
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].eh));
    end

    // Single-step: pulses at cycles 5 and 9 advance; pulse under stall does not.
    do_reset();
    start = 1'b1; mode = 1'b1;
    cycle("step_start");
    idle_inputs();
    vcount = 0;
    for (int c = 1; c <= 12; c++) begin
      step  = (c == 5) || (c == 9) || (c == 11);
      stall = (c == 11);
      cycle($sformatf("step_c%0d", c));
      if (valid) vcount++;
    end
    chk("step advances", 32'(vcount), 32'd2);
    chk("step final pc", pc, 32'h8);

    // Halt together with a redirect at PC 0x20; sticky until reset.
    do_reset();
    start = 1'b1;
    cycle("halt_start");
    idle_inputs();
    repeat (8) cycle("halt_run");
    chk("halt pre pc", pc, 32'h20);
    req = 4'b1000; halt = 1'b1;
    cycle("halt_edge");
    chk("halt pc held", pc, 32'h20);
    chk("halt flag", 32'(halted), 32'd1);
    halt = 1'b0; req = 4'b0000; start = 1'b1; step = 1'b1;
    repeat (3) cycle("halt_sticky");
    chk("halt sticky", 32'(halted), 32'd1);
    do_reset();
    chk("halt cleared pc", pc, 32'h0);
    chk("halt cleared flag", 32'(halted), 32'd0);

    // Asynchronous reset mid-cycle while running.
    start = 1'b1;
    cycle("areset_start");
    idle_inputs();
    repeat (3) cycle("areset_run");
    rst = 1'b1;
    #2;
    chk("areset pc", pc, 32'h0);
    chk("areset wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("areset src", 32'(src), 32'd0);
    chk("areset valid", 32'(valid), 32'd0);
    chk("areset halted", 32'(halted), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    check_model("areset_hold");
    rst = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(79) == 0) begin
        do_reset();
      end else begin
        start = ($urandom_range(7) == 0);
        mode  = 1'($urandom_range(1));
        req   = 4'($urandom & $urandom);
        stall = ($urandom_range(3) == 0);
        step  = ($urandom_range(2) == 0);
        halt  = ($urandom_range(49) == 0);
        for (int k = 0; k < NS; k++) tg[k*PCW +: PCW] = $urandom;
        cycle("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
